// File: rtl/uart_rx.sv
// -----------------------------------------------------------------------------
// uart_rx
//   8N1 UART receiver with mid-bit sampling, start-bit glitch rejection and
//   break handling after a framing error.
//
//   Parameters
//     CLKS_PER_BIT   clock cycles per serial bit (4..65535)
//
//   Ports
//     i_Clock        sole clock, all state on the rising edge
//     i_Reset        synchronous, active-high reset
//     i_RX_Serial    asynchronous serial line, idle high, LSB first
//     o_RX_DV        one-cycle pulse: o_RX_Byte holds a freshly received byte
//     o_RX_Byte      last correctly framed byte, held until the next o_RX_DV
//     o_RX_Active    high while a frame is in progress (START, DATA, STOP)
//     o_RX_Frame_Err one-cycle pulse: stop bit was sampled low
// -----------------------------------------------------------------------------
module uart_rx #(
    parameter int CLKS_PER_BIT = 217
) (
    input  logic       i_Clock,
    input  logic       i_Reset,
    input  logic       i_RX_Serial,
    output logic       o_RX_DV,
    output logic [7:0] o_RX_Byte,
    output logic       o_RX_Active,
    output logic       o_RX_Frame_Err
);

    localparam int SYNC_STAGES = 2;
    localparam int CNT_W       = $clog2(CLKS_PER_BIT);

    // Counter terminal values: the start bit is sampled half a bit after the
    // falling edge, every later bit one full bit period after the previous one.
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } state_t;

    // -------------------------------------------------------------------------
    // Input synchronizer (flops reset to the idle-high line level)
    // -------------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] sync_reg;
    logic [SYNC_STAGES-1:0] sync_next;
    logic                   rx_s;

    generate
        for (genvar gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
            if (gi == 0) begin : g_first
                assign sync_next[gi] = i_RX_Serial;
            end else begin : g_rest
                assign sync_next[gi] = sync_reg[gi-1];
            end
        end
    endgenerate

    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            sync_reg <= '1;
        end else begin
            sync_reg <= sync_next;
        end
    end

    assign rx_s = sync_reg[SYNC_STAGES-1];

    // -------------------------------------------------------------------------
    // Receive FSM
    // -------------------------------------------------------------------------
    state_t           state_reg,  state_next;
    logic [CNT_W-1:0] cnt_reg,    cnt_next;
    logic [2:0]       bit_reg,    bit_next;
    logic [7:0]       shift_reg,  shift_next;
    logic [7:0]       byte_reg,   byte_next;
    logic             dv_reg,     dv_next;
    logic             ferr_reg,   ferr_next;

    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            bit_reg   <= '0;
            shift_reg <= '0;
            byte_reg  <= '0;
            dv_reg    <= 1'b0;
            ferr_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            bit_reg   <= bit_next;
            shift_reg <= shift_next;
            byte_reg  <= byte_next;
            dv_reg    <= dv_next;
            ferr_reg  <= ferr_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        bit_next   = bit_reg;
        shift_next = shift_reg;
        byte_next  = byte_reg;
        dv_next    = 1'b0;
        ferr_next  = 1'b0;

        unique case (state_reg)
            IDLE: begin
                cnt_next = '0;
                if (!rx_s) begin
                    state_next = START;
                end
            end

            START: begin
                if (cnt_reg == HALF_LAST) begin
                    cnt_next = '0;
                    if (!rx_s) begin
                        state_next = DATA;
                        bit_next   = '0;
                    end else begin
                        // Line went back high before mid start bit: a glitch.
                        state_next = IDLE;
                    end
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end

            DATA: begin
                if (cnt_reg == BIT_LAST) begin
                    cnt_next   = '0;
                    shift_next = {rx_s, shift_reg[7:1]};
                    if (bit_reg == 3'd7) begin
                        state_next = STOP;
                    end else begin
                        bit_next = bit_reg + 3'd1;
                    end
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end

            STOP: begin
                if (cnt_reg == BIT_LAST) begin
                    cnt_next = '0;
                    if (rx_s) begin
                        dv_next    = 1'b1;
                        byte_next  = shift_reg;
                        state_next = IDLE;
                    end else begin
                        ferr_next  = 1'b1;
                        state_next = BREAK;
                    end
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end

            BREAK: begin
                // Wait out a held-low line so it cannot spawn phantom frames.
                cnt_next = '0;
                if (rx_s) begin
                    state_next = IDLE;
                end
            end

            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    assign o_RX_DV        = dv_reg;
    assign o_RX_Byte      = byte_reg;
    assign o_RX_Frame_Err = ferr_reg;
    assign o_RX_Active    = (state_reg == START) || (state_reg == DATA) ||
                            (state_reg == STOP);

endmodule

// File: tb/tb_uart_rx.sv
// -----------------------------------------------------------------------------
// tb_uart_rx
//   Scoreboard bench for uart_rx at 4 clocks per bit. The stimulus process
//   serialises bytes and pushes the expected outcome of each frame (byte
//   received, or framing error with the previously good byte held). A
//   monitor process pops and compares whenever the receiver pulses.
// -----------------------------------------------------------------------------
module tb_uart_rx;

    localparam int CPB = 4;

    logic       clk;
    logic       i_Reset;
    logic       i_RX_Serial;
    logic       o_RX_DV;
    logic [7:0] o_RX_Byte;
    logic       o_RX_Active;
    logic       o_RX_Frame_Err;

    uart_rx #(.CLKS_PER_BIT(CPB)) dut (
        .i_Clock        (clk),
        .i_Reset        (i_Reset),
        .i_RX_Serial    (i_RX_Serial),
        .o_RX_DV        (o_RX_DV),
        .o_RX_Byte      (o_RX_Byte),
        .o_RX_Active    (o_RX_Active),
        .o_RX_Frame_Err (o_RX_Frame_Err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected outcome of one frame
    typedef struct packed {
        logic       is_err;
        logic [7:0] data;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] last_good;      // model: byte the receiver should be holding

    // Requests from the stimulus process to the monitor
    logic       chk_zero_req;
    logic       glitch_win;
    logic       end_req;

    int         vectors;
    int         miscompares;

    // -------------------------------------------------------------------------
    // Monitor / scoreboard (sole owner of the counters)
    // -------------------------------------------------------------------------
    exp_t e;
    int   act_cnt;
    logic glitch_prev;

    task automatic chk(input string name, input logic ok, input int act, input int req);
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        act_cnt     = 0;
        glitch_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (o_RX_DV || o_RX_Frame_Err) begin
                $display("rx: dv=%0d ferr=%0d byte=0x%02h", o_RX_DV, o_RX_Frame_Err, o_RX_Byte);
                chk("dv_ferr_exclusive", !(o_RX_DV && o_RX_Frame_Err),
                    int'({o_RX_DV, o_RX_Frame_Err}), 2);
                if (exp_q.size() == 0) begin
                    chk("unexpected_pulse", 1'b0, int'({o_RX_DV, o_RX_Frame_Err}), 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("pulse_kind", o_RX_Frame_Err == e.is_err,
                        int'(o_RX_Frame_Err), int'(e.is_err));
                    chk(e.is_err ? "byte_held_on_ferr" : "rx_byte",
                        o_RX_Byte == e.data, int'(o_RX_Byte), int'(e.data));
                    if (o_RX_DV) begin
                        chk("active_low_at_dv", !o_RX_Active, int'(o_RX_Active), 0);
                    end
                end
            end
            if (chk_zero_req) begin
                chk("zero_byte",   o_RX_Byte == 8'h00, int'(o_RX_Byte), 0);
                chk("zero_dv",     !o_RX_DV,           int'(o_RX_DV), 0);
                chk("zero_active", !o_RX_Active,       int'(o_RX_Active), 0);
                chk("zero_ferr",   !o_RX_Frame_Err,    int'(o_RX_Frame_Err), 0);
            end
            if (glitch_win && o_RX_Active) begin
                act_cnt++;
            end
            if (glitch_prev && !glitch_win) begin
                chk("glitch_active_cycles", act_cnt >= 1 && act_cnt <= 2, act_cnt, 2);
                act_cnt = 0;
            end
            glitch_prev = glitch_win;
            if (end_req) begin
                chk("frames_outstanding", exp_q.size() == 0, exp_q.size(), 0);
            end
        end
    end

    // -------------------------------------------------------------------------
    // Stimulus
    // -------------------------------------------------------------------------
    task automatic drive(input logic v, input int n);
        i_RX_Serial = v;
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One 8N1 frame; the expected outcome is queued before the first bit.
    task automatic send_frame(input logic [7:0] d, input logic stop_ok);
        if (stop_ok) begin
            exp_q.push_back('{is_err: 1'b0, data: d});
            last_good = d;
        end else begin
            exp_q.push_back('{is_err: 1'b1, data: last_good});
        end
        drive(1'b0, CPB);
        for (int i = 0; i < 8; i++) begin
            drive(d[i], CPB);
        end
        drive(stop_ok, CPB);
    endtask

    initial begin
        i_RX_Serial  = 1'b1;
        i_Reset      = 1'b1;
        chk_zero_req = 1'b0;
        glitch_win   = 1'b0;
        end_req      = 1'b0;
        last_good    = 8'h00;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk_zero_req = 1'b1;
        drive(1'b1, 1);
        chk_zero_req = 1'b0;
        i_Reset      = 1'b0;
        drive(1'b1, 5);

        // Single frame
        send_frame(8'h41, 1'b1);
        drive(1'b1, 6);

        // One-cycle glitch on an idle line
        glitch_win = 1'b1;
        drive(1'b0, 1);
        drive(1'b1, 12);
        glitch_win = 1'b0;
        drive(1'b1, 4);

        // Back-to-back "A".."y"
        for (int c = 8'h41; c <= 8'h79; c++) begin
            send_frame(8'(c), 1'b1);
        end
        drive(1'b1, 6);

        // Framing error, break held low, then recovery
        send_frame(8'h55, 1'b0);
        drive(1'b0, 40);
        drive(1'b1, 6);
        send_frame(8'hA3, 1'b1);
        drive(1'b1, 6);

        // Reset in the middle of data bit 3 of 0x7E; frame must vanish
        begin
            logic [7:0] d;
            d = 8'h7E;
            drive(1'b0, CPB);
            for (int i = 0; i < 3; i++) begin
                drive(d[i], CPB);
            end
            drive(d[3], 2);
            i_Reset = 1'b1;
            drive(d[3], 1);
            i_Reset      = 1'b0;
            chk_zero_req = 1'b1;
            last_good    = 8'h00;
            drive(1'b1, 1);
            chk_zero_req = 1'b0;
            drive(1'b1, 12);
        end
        send_frame(8'h0F, 1'b1);
        drive(1'b1, 6);

        // All-zero / all-one payloads
        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        drive(1'b1, 6);

        // Randomized traffic with occasional framing errors and breaks
        for (int n = 0; n < 150; n++) begin
            logic [7:0] d;
            logic       ok;
            d  = 8'($urandom_range(0, 255));
            ok = ($urandom_range(0, 9) != 0);
            send_frame(d, ok);
            if (!ok) begin
                drive(1'b0, $urandom_range(1, 20));
                drive(1'b1, $urandom_range(2, 5));
            end else begin
                int gap;
                gap = $urandom_range(0, 3);
                if (gap > 0) begin
                    drive(1'b1, gap);
                end
            end
        end

        drive(1'b1, 20);
        end_req = 1'b1;
        drive(1'b1, 1);
        end_req = 1'b0;
        drive(1'b1, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // Time bound on the whole run
    initial begin
        #5ms;
        $display("FAIL timeout: got no completion, expected finish before time limit");
        $fatal(1, "simulation time limit exceeded");
    end

endmodule
